// File: rtl/branch_resolve.sv
// EX-stage branch resolution: taken decode, registered PC redirect with valid/ready, wrong-path flush, stats.
// Redirect appears the cycle after a taken resolve; it is held until fetch accepts it, and flush covers that wait.
module branch_resolve #(
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic [2:0]       ex_funct3,
  input  logic [31:0]      ex_target,
  input  logic             br_eq,
  input  logic             br_lt,
  output logic             br_unsign,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [31:0]      redirect_pc,
  output logic             flush_o,
  output logic             illegal_br,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;

  localparam int DW = (FLUSH_DEPTH > 2) ? $clog2(FLUSH_DEPTH) : 1;
  localparam logic [DW-1:0]    CNT_INIT = (FLUSH_DEPTH > 1) ? DW'(FLUSH_DEPTH - 2) : '0;
  localparam logic [DW-1:0]    CNT_ONE  = DW'(1);
  localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);

  state_t         state, state_nxt;
  logic [DW-1:0]  cnt, cnt_nxt;
  logic           resolve;
  logic           legal_f3;
  logic           cond_taken;
  logic           cond_res;
  logic           taken;
  logic [31:0]    target;

  assign br_unsign = ex_is_branch & ex_funct3[1];

  // Anything presented outside IDLE is on the wrong path and must not resolve.
  assign resolve  = (state == IDLE) & ex_valid & $onehot({ex_is_branch, ex_is_jal, ex_is_jalr});
  assign legal_f3 = (ex_funct3[2:1] != 2'b01);

  always_comb begin
    cond_taken = 1'b0;
    case (ex_funct3)
      3'b000:  cond_taken = br_eq;
      3'b001:  cond_taken = ~br_eq;
      3'b100:  cond_taken = br_lt;
      3'b101:  cond_taken = ~br_lt;
      3'b110:  cond_taken = br_lt;
      3'b111:  cond_taken = ~br_lt;
      default: cond_taken = 1'b0;
    endcase
  end

  assign cond_res = resolve & ex_is_branch & legal_f3;
  assign taken    = resolve & (ex_is_jal | ex_is_jalr | (ex_is_branch & legal_f3 & cond_taken));
  assign target   = ex_is_jalr ? {ex_target[31:1], 1'b0} : ex_target;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    redirect_valid = 1'b0;
    flush_o        = 1'b0;
    case (state)
      IDLE: begin
        if (taken) state_nxt = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        flush_o        = 1'b1;
        if (redirect_ready) begin
          if (FLUSH_DEPTH == 1) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DRAIN;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      DRAIN: begin
        flush_o = 1'b1;
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - CNT_ONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      redirect_pc  <= '0;
      illegal_br   <= 1'b0;
      branch_count <= '0;
      taken_count  <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      illegal_br <= resolve & ex_is_branch & ~legal_f3;
      if (taken) redirect_pc <= target;
      if (cond_res) begin
        branch_count <= branch_count + STAT_ONE;
        if (cond_taken) taken_count <= taken_count + STAT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed table, corner sequences and random traffic against a transaction-level model.
module tb_branch_resolve;
  localparam int FD = 2;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [2:0]    ex_funct3;
  logic [31:0]   ex_target;
  logic          br_eq, br_lt, br_unsign;
  logic          redirect_valid, redirect_ready;
  logic [31:0]   redirect_pc;
  logic          flush_o, illegal_br;
  logic [CW-1:0] branch_count, taken_count;
  logic [31:0]   op_a, op_b;

  branch_resolve #(.FLUSH_DEPTH(FD), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3), .ex_target(ex_target),
    .br_eq(br_eq), .br_lt(br_lt), .br_unsign(br_unsign), .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(redirect_pc), .flush_o(flush_o),
    .illegal_br(illegal_br), .branch_count(branch_count), .taken_count(taken_count)
  );

  // Comparator stand-in: operands are the bench's, signedness follows the DUT's select.
  assign br_eq = (op_a == op_b);
  assign br_lt = br_unsign ? (op_a < op_b) : ($signed(op_a) < $signed(op_b));

  always #5 clock = ~clock;

  bit            m_pend;
  logic [31:0]   m_pc;
  int            m_drain;
  bit            m_ill;
  logic [CW-1:0] m_bc, m_tc;
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit isa_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // One clock: compare against the model mid-cycle, advance the model, then cross the edge.
  task automatic step();
    bit busy, take, ill;
    logic [31:0] tgt;
    @(negedge clock);
    busy = m_pend || (m_drain > 0);
    chk("br_unsign", br_unsign, ex_is_branch && (ex_funct3 == 3'd2 || ex_funct3 == 3'd3 ||
                                                 ex_funct3 == 3'd6 || ex_funct3 == 3'd7));
    chk("redirect_valid", redirect_valid, m_pend);
    chk("redirect_pc", redirect_pc, m_pc);
    chk("flush_o", flush_o, busy);
    chk("illegal_br", illegal_br, m_ill);
    chk("branch_count", branch_count, m_bc);
    chk("taken_count", taken_count, m_tc);
    if (reset) begin
      m_pend = 0; m_pc = '0; m_drain = 0; m_ill = 0; m_bc = '0; m_tc = '0;
    end else begin
      take = 0; ill = 0; tgt = ex_target;
      if (!busy && ex_valid && (int'(ex_is_branch) + int'(ex_is_jal) + int'(ex_is_jalr)) == 1) begin
        if (ex_is_branch) begin
          if (ex_funct3 == 3'd2 || ex_funct3 == 3'd3) ill = 1;
          else begin
            m_bc = m_bc + 1'b1;
            if (isa_taken(ex_funct3, op_a, op_b)) begin
              m_tc = m_tc + 1'b1;
              take = 1;
            end
          end
        end else begin
          take = 1;
          if (ex_is_jalr) tgt = ex_target & 32'hffff_fffe;
        end
      end
      if (m_pend) begin
        if (redirect_ready) begin m_pend = 0; m_drain = FD - 1; end
      end else if (m_drain > 0) m_drain--;
      if (take) begin m_pend = 1; m_pc = tgt; end
      m_ill = ill;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic br, input logic jal, input logic jalr,
                       input logic [2:0] f3, input logic [31:0] tgt, input logic [31:0] a,
                       input logic [31:0] b);
    ex_valid = v; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
    ex_funct3 = f3; ex_target = tgt; op_a = a; op_b = b;
  endtask

  task automatic idle_cycles(input int n);
    drive(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h1);
    redirect_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    logic        br, jal, jalr;
    logic [2:0]  f3;
    logic [31:0] tgt, a, b;
    logic        e_uns, e_tk, e_ill;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int fl, rv_cycles;
    logic [CW-1:0] bc0, tc0;

    tbl[0]  = '{1, 0, 0, 3'd0, 32'h0000_0100, 32'd5,        32'd5, 0, 1, 0, 32'h0000_0100};
    tbl[1]  = '{1, 0, 0, 3'd0, 32'h0000_0104, 32'd5,        32'd6, 0, 0, 0, 32'h0};
    tbl[2]  = '{1, 0, 0, 3'd1, 32'h0000_0108, 32'd5,        32'd6, 0, 1, 0, 32'h0000_0108};
    tbl[3]  = '{1, 0, 0, 3'd4, 32'h0000_010c, 32'hffff_ffff, 32'd1, 0, 1, 0, 32'h0000_010c};
    tbl[4]  = '{1, 0, 0, 3'd5, 32'h0000_0110, 32'hffff_ffff, 32'd1, 0, 0, 0, 32'h0};
    tbl[5]  = '{1, 0, 0, 3'd6, 32'h0000_0114, 32'hffff_ffff, 32'd1, 1, 0, 0, 32'h0};
    tbl[6]  = '{1, 0, 0, 3'd7, 32'h0000_0118, 32'hffff_ffff, 32'd1, 1, 1, 0, 32'h0000_0118};
    tbl[7]  = '{1, 0, 0, 3'd2, 32'h0000_011c, 32'd3,        32'd3, 1, 0, 1, 32'h0};
    tbl[8]  = '{1, 0, 0, 3'd3, 32'h0000_0120, 32'd3,        32'd3, 1, 0, 1, 32'h0};
    tbl[9]  = '{0, 1, 0, 3'd0, 32'h0000_0200, 32'd1,        32'd2, 0, 1, 0, 32'h0000_0200};
    tbl[10] = '{0, 0, 1, 3'd0, 32'h0000_2001, 32'd1,        32'd2, 0, 1, 0, 32'h0000_2000};
    tbl[11] = '{1, 1, 0, 3'd0, 32'h0000_0300, 32'd7,        32'd7, 0, 0, 0, 32'h0};

    reset = 1'b1;
    redirect_ready = 1'b1;
    drive(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h1);
    m_pend = 0; m_pc = '0; m_drain = 0; m_ill = 0; m_bc = '0; m_tc = '0;
    @(posedge clock); #1;
    step();
    reset = 1'b0;
    chk("reset redirect_valid", redirect_valid, 0);
    chk("reset redirect_pc", redirect_pc, 0);
    chk("reset flush_o", flush_o, 0);
    chk("reset branch_count", branch_count, 0);
    idle_cycles(2);

    for (int i = 0; i < 12; i++) begin
      drive(1, tbl[i].br, tbl[i].jal, tbl[i].jalr, tbl[i].f3, tbl[i].tgt, tbl[i].a, tbl[i].b);
      #1;
      chk($sformatf("vec%0d br_unsign", i), br_unsign, tbl[i].e_uns);
      step();
      chk($sformatf("vec%0d redirect_valid", i), redirect_valid, tbl[i].e_tk);
      chk($sformatf("vec%0d illegal_br", i), illegal_br, tbl[i].e_ill);
      if (tbl[i].e_tk) chk($sformatf("vec%0d redirect_pc", i), redirect_pc, tbl[i].e_pc);
      idle_cycles(4);
    end

    // JALR with fetch stalling the redirect for three cycles.
    bc0 = branch_count; tc0 = taken_count;
    redirect_ready = 1'b0;
    drive(1, 0, 0, 1, 3'd0, 32'h0000_1003, 32'h0, 32'h0);
    step();
    drive(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h1);
    fl = 0;
    for (int i = 0; i < 10; i++) begin
      if (flush_o) fl++;
      if (i < 4) begin
        chk("jalr stall redirect_pc", redirect_pc, 32'h0000_1002);
        chk("jalr stall redirect_valid", redirect_valid, 1);
      end
      redirect_ready = (i >= 3);
      step();
    end
    chk("jalr stall flush length", fl, 5);
    chk("jalr branch_count", branch_count, bc0);
    chk("jalr taken_count", taken_count, tc0);

    // Taken BNE followed by a wrong-path BEQ while the redirect waits.
    bc0 = branch_count;
    redirect_ready = 1'b0;
    drive(1, 1, 0, 0, 3'd1, 32'h0000_4000, 32'd1, 32'd2);
    step();
    drive(1, 1, 0, 0, 3'd0, 32'h0000_5000, 32'd9, 32'd9);
    rv_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      if (redirect_valid) begin
        rv_cycles++;
        chk("bne redirect_pc", redirect_pc, 32'h0000_4000);
      end
      if (i == 1) begin
        drive(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h1);
        redirect_ready = 1'b1;
      end
      step();
    end
    chk("bne single redirect cycles", rv_cycles, 2);
    chk("bne branch_count", branch_count, bc0 + 1'b1);

    // Reset while a redirect is pending, then counter wrap.
    redirect_ready = 1'b0;
    drive(1, 0, 1, 0, 3'd0, 32'h0000_6000, 32'h0, 32'h0);
    step();
    drive(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset redirect_valid", redirect_valid, 0);
    chk("midreset redirect_pc", redirect_pc, 0);
    chk("midreset flush_o", flush_o, 0);
    chk("midreset illegal_br", illegal_br, 0);
    chk("midreset taken_count", taken_count, 0);
    redirect_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, 0, 3'd0, 32'h0, 32'd1, 32'd2);
      step();
      if (i == 14) chk("wrap branch_count max", branch_count, 15);
    end
    chk("wrap branch_count zero", branch_count, 0);
    chk("wrap taken_count", taken_count, 0);
    idle_cycles(2);

    for (int i = 0; i < 800; i++) begin
      int k;
      k = $urandom_range(0, 9);
      ex_valid       = ($urandom_range(0, 3) != 0);
      ex_is_branch   = (k <= 4);
      ex_is_jal      = (k == 5);
      ex_is_jalr     = (k == 6);
      if (k == 7) begin
        ex_is_branch = 1'b1;
        ex_is_jal    = $urandom_range(0, 1) != 0;
        ex_is_jalr   = ~ex_is_jal;
      end
      ex_funct3      = 3'($urandom_range(0, 7));
      ex_target      = $urandom;
      op_a           = 32'($urandom_range(0, 3)) - 32'd2;
      op_b           = 32'($urandom_range(0, 3)) - 32'd2;
      redirect_ready = $urandom_range(0, 1) != 0;
      reset          = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    idle_cycles(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
